// File: rtl/laser310_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | laser310_pkg : shared bank-select constants and bus-cycle state type  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package laser310_pkg;

  localparam logic [1:0] BANK_DEFAULT = 2'b01;
  localparam logic [3:0] PORT_BANK    = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    DONE = 2'd2
  } bank_state_t;

  // Page 0 backs B800h-BFFFh permanently, so a write of 00 selects page 1.
  function automatic logic [1:0] bank_value(input logic [1:0] d);
    return (d == 2'b00) ? BANK_DEFAULT : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_sync : WIDTH x STAGES flop-chain synchroniser, per-bit reset value |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES*WIDTH-1:0] r_chain;

  // Stage 0 sits in the low slice; each edge shifts one slice upward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[(STAGES-1)*WIDTH-1:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/bank_latch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bank_latch : qualified I/O-port-7xh bank register with write LED      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bank_latch
  import laser310_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int QUAL_CYCLES = 2,
  parameter int LED_CYCLES  = 1_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] AddrIO,
  input  logic       IORQ_N,
  input  logic       WR_N,
  input  logic       M1_N,
  input  logic [1:0] D1D0,
  output logic [1:0] bank,
  output logic       bank_wr,
  output logic       led_bank
);

  localparam int              c_BUS_W  = 9;
  localparam logic [c_BUS_W-1:0] c_BUS_RST = 9'b0000_1_1_1_00;
  localparam int              c_QUAL_W = $clog2(QUAL_CYCLES + 1);
  localparam int              c_LED_W  = $clog2(LED_CYCLES + 1);
  localparam logic [c_QUAL_W-1:0] c_QUAL_LAST = c_QUAL_W'(QUAL_CYCLES);
  localparam logic [c_LED_W-1:0]  c_LED_INIT  = c_LED_W'(LED_CYCLES);

  logic [c_BUS_W-1:0] w_bus_sync;
  logic [3:0]         w_addr;
  logic               w_iorq_n;
  logic               w_wr_n;
  logic               w_m1_n;
  logic [1:0]         w_data;
  logic               w_cond;
  logic               w_load;

  bank_state_t         r_state;
  logic [c_QUAL_W-1:0] r_qual_cnt;
  logic [c_LED_W-1:0]  r_led_cnt;

  bus_sync #(
    .WIDTH     (c_BUS_W),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (c_BUS_RST)
  ) u_bus_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_d   ({AddrIO, IORQ_N, WR_N, M1_N, D1D0}),
    .o_q   (w_bus_sync)
  );

  assign {w_addr, w_iorq_n, w_wr_n, w_m1_n, w_data} = w_bus_sync;

  // M1 low alongside IORQ is an interrupt acknowledge, never a port write.
  assign w_cond = !w_iorq_n && !w_wr_n && w_m1_n && (w_addr == PORT_BANK);

  assign w_load = w_cond &&
                  (((r_state == IDLE) && (QUAL_CYCLES <= 1)) ||
                   ((r_state == QUAL) && ((r_qual_cnt + c_QUAL_W'(1)) == c_QUAL_LAST)));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_qual_cnt <= '0;
      bank       <= BANK_DEFAULT;
      bank_wr    <= 1'b0;
    end else begin
      bank_wr <= 1'b0;
      if (w_load) begin
        bank       <= bank_value(w_data);
        bank_wr    <= 1'b1;
        r_qual_cnt <= '0;
        r_state    <= DONE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cond) begin
              r_qual_cnt <= c_QUAL_W'(1);
              r_state    <= QUAL;
            end else begin
              r_qual_cnt <= '0;
            end
          end
          QUAL: begin
            if (w_cond) begin
              r_qual_cnt <= r_qual_cnt + c_QUAL_W'(1);
            end else begin
              r_qual_cnt <= '0;
              r_state    <= IDLE;
            end
          end
          // Hold off until the bus cycle ends so one long /WR loads once.
          DONE: begin
            if (w_iorq_n || w_wr_n) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_qual_cnt <= '0;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_led_cnt <= '0;
    end else if (w_load) begin
      r_led_cnt <= c_LED_INIT;
    end else if (r_led_cnt != '0) begin
      r_led_cnt <= r_led_cnt - c_LED_W'(1);
    end
  end

  assign led_bank = (r_led_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_bank_latch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bank_latch : scoreboard bench for bank_latch                       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_bank_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] addr;
  logic       iorq_n;
  logic       wr_n;
  logic       m1_n;
  logic [1:0] data;
  logic [1:0] bank;
  logic       bank_wr;
  logic       led_bank;

  int         checks   = 0;
  int         failures = 0;
  int         wr_count = 0;
  int         base;
  int         n;
  bit         ok;
  logic       prev_wr  = 1'b0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  bank_latch #(
    .SYNC_STAGES (2),
    .QUAL_CYCLES (2),
    .LED_CYCLES  (16)
  ) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .AddrIO   (addr),
    .IORQ_N   (iorq_n),
    .WR_N     (wr_n),
    .M1_N     (m1_n),
    .D1D0     (data),
    .bank     (bank),
    .bank_wr  (bank_wr),
    .led_bank (led_bank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every bank_wr pulse consumes one expected bank value.
  always @(negedge clk) begin
    if (bank_wr === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) check("unexpected_bank_wr", bank_wr, 0);
      else check("bank_on_wr", bank, exp_q.pop_front());
      check("bank_wr_single", prev_wr, 0);
    end
    prev_wr = bank_wr;
  end

  task automatic bus_off();
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
    addr   = 4'h0;
  endtask

  task automatic bus_on(input logic [3:0] port, input logic [1:0] d, input logic m1);
    @(negedge clk);
    addr   = port;
    data   = d;
    m1_n   = m1;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic bus_cycle(input logic [3:0] port, input logic [1:0] d, input int len, input logic m1);
    bus_on(port, d, m1);
    idle(len);
    bus_off();
    idle(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    data  = 2'b00;
    bus_off();
    idle(3);
    check("rst_bank", bank, 1);
    check("rst_bank_wr", bank_wr, 0);
    check("rst_led", led_bank, 0);
    rst_n = 1'b1;
    idle(3);

    // Port 70h, data 2, strobes low for 10 CLK: load on edge 4, LED 16 cycles.
    base = wr_count;
    exp_q.push_back(2'b10);
    @(negedge clk);
    addr = 4'h7; data = 2'b10; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lat_bank_e3", bank, 1);
    check("lat_wr_e3", bank_wr, 0);
    @(posedge clk);
    #1;
    check("lat_bank_e4", bank, 2);
    check("lat_wr_e4", bank_wr, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 6) begin iorq_n = 1'b1; wr_n = 1'b1; end
      if (led_bank) n++;
    end
    check("led_cycles", n, 16);
    check("pulses_first_write", wr_count - base, 1);

    // Port 7Fh: data 0 maps to page 1, then data 3.
    exp_q.push_back(2'b01);
    bus_cycle(4'h7, 2'b00, 10, 1'b1);
    check("bank_data0", bank, 1);
    exp_q.push_back(2'b11);
    bus_cycle(4'h7, 2'b11, 10, 1'b1);
    check("bank_data3", bank, 3);

    // Wrong port and interrupt acknowledge leave the bank alone.
    base = wr_count;
    bus_cycle(4'h6, 2'b10, 10, 1'b1);
    check("bank_port60", bank, 3);
    bus_cycle(4'h7, 2'b10, 10, 1'b0);
    check("bank_intack", bank, 3);
    check("pulses_rejected", wr_count - base, 0);

    // One-CLK glitch rejected; a 200-CLK cycle loads once.
    base = wr_count;
    bus_cycle(4'h7, 2'b10, 1, 1'b1);
    check("bank_glitch", bank, 3);
    check("pulses_glitch", wr_count - base, 0);
    exp_q.push_back(2'b10);
    bus_cycle(4'h7, 2'b10, 200, 1'b1);
    check("bank_long", bank, 2);
    check("pulses_long", wr_count - base, 1);

    // Back-to-back writes while the LED is lit; second pulse reloads to 16.
    base = wr_count;
    exp_q.push_back(2'b10);
    bus_on(4'h7, 2'b10, 1'b1);
    idle(6);
    bus_off();
    idle(4);
    check("led_lit_between", led_bank, 1);
    exp_q.push_back(2'b11);
    bus_on(4'h7, 2'b11, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bank_wr) begin ok = 1'b1; break; end
    end
    check("second_wr_seen", ok, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 2) bus_off();
      if (led_bank) n++;
      @(negedge clk);
    end
    check("led_reload", n, 16);
    check("bank_b2b", bank, 3);
    check("pulses_b2b", wr_count - base, 2);

    // Reset in the middle of QUAL while the LED is lit.
    base = wr_count;
    exp_q.push_back(2'b10);
    bus_cycle(4'h7, 2'b10, 6, 1'b1);
    bus_on(4'h7, 2'b11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("led_before_reset", led_bank, 1);
    rst_n = 1'b0;
    #1;
    check("midqual_rst_bank", bank, 1);
    check("midqual_rst_wr", bank_wr, 0);
    check("midqual_rst_led", led_bank, 0);
    @(negedge clk);
    bus_off();
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check("bank_after_release", bank, 1);
    check("pulses_reset_test", wr_count - base, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
